ser_word_collector: RTL and testbench
=====================================

SER_WORD_COLLECTOR -- requirements
Module: ser_word_collector

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: frame/word length in bits; legal range 2..32.
REQ-002 The block SHALL have parameter SHIFT_DIRECTION, default "RIGHT": "RIGHT" means the upstream shift register emits LSB first; "LEFT" means it emits MSB first.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port aclr, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port sclr, input, 1 bit: synchronous clear, active-high.
REQ-006 The block SHALL have port bit_valid, input, 1 bit: qualifies bit_in this cycle; it is driven from the upstream shift enable.
REQ-007 The block SHALL have port bit_in, input, 1 bit: serial data; it is driven from the upstream shiftout.
REQ-008 The block SHALL have port start, input, 1 bit: marks bit_in as bit 0 of a new frame; it is ignored when bit_valid=0.
REQ-009 The block SHALL have port data_out, output, WIDTH bits: the assembled word, registered.
REQ-010 The block SHALL have port out_valid, output, 1 bit: data_out holds an unconsumed word.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts data_out on a clock edge where out_valid=1.
REQ-012 The block SHALL have port busy, output, 1 bit: high while in the COLLECT state.
REQ-013 The block SHALL have port overrun, output, 1 bit: sticky flag marking a dropped word.

Function
REQ-014 The block SHALL implement a two-state FSM (IDLE, COLLECT), a bit counter cnt of width clog2(WIDTH), and a WIDTH-bit accumulator acc.
REQ-015 In IDLE: bit_valid=1 with start=1 SHALL capture bit_in as frame bit 0, set cnt=1, and move to COLLECT; bit_valid=1 with start=0 SHALL be discarded, and the FSM SHALL stay in IDLE.
REQ-016 In COLLECT: bit_valid=1 with start=0 SHALL capture bit_in as frame bit cnt and increment cnt; bit_valid=0 SHALL hold all state, so gaps of any length are legal.
REQ-017 In COLLECT: bit_valid=1 with start=1 SHALL abort the partial frame without output, capture bit_in as bit 0, set cnt=1, and stay in COLLECT.
REQ-018 Bit placement: for "RIGHT", frame bit k SHALL go to data_out[k]; for "LEFT", frame bit k SHALL go to data_out[WIDTH-1-k].
REQ-019 Frame completion occurs on a rising edge that samples bit_valid=1, start=0, and cnt=WIDTH-1; on that edge the FSM SHALL return to IDLE and cnt SHALL become 0.
REQ-020 On completion with out_valid=0, or with out_valid=1 and out_ready=1, the block SHALL load the assembled word into data_out and set out_valid=1 on the same edge; latency is 0 cycles after the last bit's edge.
REQ-021 On completion with out_valid=1 and out_ready=0, the block SHALL drop the new word, leave data_out and out_valid unchanged, and set overrun=1.
REQ-022 When out_valid=1 and out_ready=1 without a completion on that edge, out_valid SHALL go to 0 and data_out SHALL hold its value.
REQ-023 data_out SHALL change only on an edge that sets out_valid, or on a clear.
REQ-024 overrun SHALL remain 1 until sclr or aclr is applied; out_ready SHALL NOT clear it.
REQ-025 sclr=1 SHALL take priority over all other inputs on its edge, and SHALL force the same values as aclr.

Reset
REQ-026 aclr=1 SHALL immediately, without waiting for a clock edge, force state=IDLE, cnt=0, acc=0, data_out=0, out_valid=0, overrun=0, and busy=0.
REQ-027 After aclr deasserts, the first rising edge SHALL be processed normally; a frame in progress when aclr asserted is lost.

Verification
REQ-028 Scenario: RIGHT, WIDTH=8; send bits 1,0,1,1,1,0,1,0 with start on the first bit, out_ready=1 -> data_out=8'h5D and out_valid=1 on the 8th bit's edge, out_valid=0 one edge later, busy high for bits 1..7.
REQ-029 Scenario: LEFT; send the same bit sequence with 3 idle cycles inserted after bit 4 -> data_out=8'hBA, and no output during the gap.
REQ-030 Scenario: out_ready=0; send two full frames 0x5D then 0x0F -> data_out stays 8'h5D, out_valid=1, overrun=1; then sclr -> overrun=0, out_valid=0, data_out=0.
REQ-031 Scenario: start reasserted on the 5th bit of a frame, followed by 8 bits of 0xA5 -> exactly one word, 8'hA5, is delivered, and the partial frame produces no output.
REQ-032 Scenario: aclr pulsed asynchronously (between edges) after the 3rd bit -> outputs are 0 before the next edge, and a following 8-bit frame of 0x3C delivers 8'h3C.
REQ-033 Scenario: completion on the same edge as out_ready=1 while out_valid=1 -> the new word replaces the old one, out_valid stays 1, and overrun stays 0.

Source files
------------

// File: rtl/ser_word_collector.sv
// Collects a start-framed serial bit stream into WIDTH-bit words with a one-word
// valid/ready output buffer and a sticky overrun flag for words dropped while that buffer is full.
module ser_word_collector #(
   parameter int    WIDTH           = 8,
   parameter string SHIFT_DIRECTION = "RIGHT"
) (
   input  logic             clock,
   input  logic             aclr,
   input  logic             sclr,
   input  logic             bit_valid,
   input  logic             bit_in,
   input  logic             start,
   output logic [WIDTH-1:0] data_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             overrun
);

   localparam int            CW      = $clog2(WIDTH);
   localparam bit            IS_LEFT = (SHIFT_DIRECTION == "LEFT");
   localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      COLLECT
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             out_valid_q, out_valid_d;
   logic             overrun_q, overrun_d;

   // merged: accumulator with bit_in dropped into the slot for frame bit cnt_q.
   // first_word: a fresh frame holding only bit_in as frame bit 0.
   logic [WIDTH-1:0] merged;
   logic [WIDTH-1:0] first_word;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slot
      localparam logic [CW-1:0] SLOT = IS_LEFT ? CW'(WIDTH - 1 - gi) : CW'(gi);
      assign merged[gi]     = (cnt_q == SLOT) ? bit_in : acc_q[gi];
      assign first_word[gi] = (SLOT == '0) ? bit_in : 1'b0;
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      data_d      = data_q;
      out_valid_d = out_valid_q;
      overrun_d   = overrun_q;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (bit_valid) begin
         if (start) begin
            // A start mid-frame silently abandons the partial word.
            state_d = COLLECT;
            cnt_d   = CW'(1);
            acc_d   = first_word;
         end else if (state_q == COLLECT) begin
            acc_d = merged;
            if (cnt_q == LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               if (!out_valid_q || out_ready) begin
                  data_d      = merged;
                  out_valid_d = 1'b1;
               end else begin
                  overrun_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
      end

      if (sclr) begin
         state_d     = IDLE;
         cnt_d       = '0;
         acc_d       = '0;
         data_d      = '0;
         out_valid_d = 1'b0;
         overrun_d   = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         data_q      <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         data_q      <= data_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign data_out  = data_q;
   assign out_valid = out_valid_q;
   assign busy      = (state_q == COLLECT);
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_ser_word_collector.sv
// Drives identical serial traffic into an LSB-first and an MSB-first collector and
// checks delivered words against per-instance scoreboards plus direct flag checks.
module tb_ser_word_collector;

   logic       clock = 1'b0;
   logic       aclr, sclr, bit_valid, bit_in, start, out_ready;
   logic [7:0] data_out_r, data_out_l;
   logic       out_valid_r, out_valid_l, busy_r, busy_l, overrun_r, overrun_l;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] exp_q_r[$];
   logic [7:0] exp_q_l[$];

   always #5 clock = ~clock;

   ser_word_collector #(.WIDTH(8), .SHIFT_DIRECTION("RIGHT")) u_dut_r (
      .clock(clock), .aclr(aclr), .sclr(sclr), .bit_valid(bit_valid), .bit_in(bit_in),
      .start(start), .data_out(data_out_r), .out_valid(out_valid_r), .out_ready(out_ready),
      .busy(busy_r), .overrun(overrun_r)
   );

   ser_word_collector #(.WIDTH(8), .SHIFT_DIRECTION("LEFT")) u_dut_l (
      .clock(clock), .aclr(aclr), .sclr(sclr), .bit_valid(bit_valid), .bit_in(bit_in),
      .start(start), .data_out(data_out_l), .out_valid(out_valid_l), .out_ready(out_ready),
      .busy(busy_l), .overrun(overrun_l)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] rev8(input logic [7:0] w);
      logic [7:0] r;
      for (int k = 0; k < 8; k++) r[k] = w[7-k];
      return r;
   endfunction

   // Inputs are stable from just after one rising edge until the next, so a
   // handshake visible on the falling edge is the one the next rising edge takes.
   always @(negedge clock) begin
      if (!aclr && !sclr && out_valid_r && out_ready) begin
         chk("sb_depth_r", 32'(exp_q_r.size() != 0), 1);
         if (exp_q_r.size() != 0) chk("sb_word_r", data_out_r, exp_q_r.pop_front());
         $display("[TB] RIGHT word consumed: %02h", data_out_r);
      end
      if (!aclr && !sclr && out_valid_l && out_ready) begin
         chk("sb_depth_l", 32'(exp_q_l.size() != 0), 1);
         if (exp_q_l.size() != 0) chk("sb_word_l", data_out_l, exp_q_l.pop_front());
         $display("[TB] LEFT  word consumed: %02h", data_out_l);
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic s, input logic b);
      bit_valid = v;
      start     = s;
      bit_in    = b;
      step();
   endtask

   // Frame bit k is w[k]: the LSB-first instance must rebuild w, the MSB-first one rev8(w).
   task automatic send_frame(input logic [7:0] w, input bit push, input int gap, input bit rdy_last);
      for (int k = 0; k < 8; k++) begin
         if (k == 7) begin
            if (push) begin
               exp_q_r.push_back(w);
               exp_q_l.push_back(rev8(w));
            end
            if (rdy_last) out_ready = 1'b1;
         end
         drive(1'b1, k == 0, w[k]);
         chk(k < 7 ? "busy_mid" : "busy_done", {busy_r, busy_l}, k < 7 ? 2'b11 : 2'b00);
         if (k == 3) begin
            for (int g = 0; g < gap; g++) begin
               drive(1'b0, 1'b0, 1'b0);
               chk("gap_no_out", {out_valid_r, out_valid_l, busy_r, busy_l}, 4'b0011);
            end
         end
      end
      bit_valid = 1'b0;
      start     = 1'b0;
   endtask

   initial begin
      aclr = 1'b1; sclr = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; start = 1'b0; out_ready = 1'b1;
      #3;
      chk("rst_data", {data_out_r, data_out_l}, 16'h0000);
      chk("rst_flags", {out_valid_r, out_valid_l, busy_r, busy_l, overrun_r, overrun_l}, 6'b0);
      @(posedge clock); #3 aclr = 1'b0;
      step();

      $display("[TB] bits without start while idle");
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1);
      chk("idle_discard", {out_valid_r, out_valid_l, busy_r, busy_l}, 4'b0);

      $display("[TB] frame 5D, ready high");
      send_frame(8'h5D, 1'b1, 0, 1'b0);
      chk("f1_data_r", data_out_r, 8'h5D);
      chk("f1_data_l", data_out_l, 8'hBA);
      chk("f1_valid", {out_valid_r, out_valid_l}, 2'b11);
      drive(1'b0, 1'b0, 1'b0);
      chk("f1_valid_drop", {out_valid_r, out_valid_l}, 2'b00);
      chk("f1_data_hold", {data_out_r, data_out_l}, 16'h5DBA);

      $display("[TB] frame 5D with idle gap");
      send_frame(8'h5D, 1'b1, 3, 1'b0);
      chk("f2_data_l", data_out_l, 8'hBA);
      drive(1'b0, 1'b0, 1'b0);

      $display("[TB] two frames while ready low");
      out_ready = 1'b0;
      send_frame(8'h5D, 1'b1, 0, 1'b0);
      chk("ov_none_yet", {overrun_r, overrun_l}, 2'b00);
      send_frame(8'h0F, 1'b0, 0, 1'b0);
      chk("ov_data_kept", {data_out_r, data_out_l}, 16'h5DBA);
      chk("ov_flags", {out_valid_r, out_valid_l, overrun_r, overrun_l}, 4'b1111);
      out_ready = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      chk("ov_sticky", {out_valid_r, out_valid_l, overrun_r, overrun_l}, 4'b0011);
      out_ready = 1'b0;
      sclr = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      sclr = 1'b0;
      out_ready = 1'b1;
      chk("sclr_flags", {out_valid_r, out_valid_l, overrun_r, overrun_l}, 4'b0);
      chk("sclr_data", {data_out_r, data_out_l}, 16'h0000);

      $display("[TB] restart on 5th bit, then A5");
      for (int k = 0; k < 4; k++) drive(1'b1, k == 0, 1'b1);
      send_frame(8'hA5, 1'b1, 0, 1'b0);
      chk("restart_data", {data_out_r, data_out_l}, 16'hA5A5);
      drive(1'b0, 1'b0, 1'b0);

      $display("[TB] async clear mid-frame, then 3C");
      for (int k = 0; k < 3; k++) drive(1'b1, k == 0, 1'b1);
      bit_valid = 1'b0;
      start     = 1'b0;
      #2 aclr = 1'b1;
      #1;
      chk("aclr_data", {data_out_r, data_out_l}, 16'h0000);
      chk("aclr_flags", {out_valid_r, out_valid_l, busy_r, busy_l, overrun_r, overrun_l}, 6'b0);
      #2 aclr = 1'b0;
      send_frame(8'h3C, 1'b1, 0, 1'b0);
      chk("post_aclr_data", {data_out_r, data_out_l}, 16'h3C3C);
      drive(1'b0, 1'b0, 1'b0);

      $display("[TB] completion on same edge as consume");
      out_ready = 1'b0;
      send_frame(8'h5D, 1'b1, 0, 1'b0);
      send_frame(8'h0F, 1'b1, 0, 1'b1);
      chk("replace_data", {data_out_r, data_out_l}, 16'h0FF0);
      chk("replace_flags", {out_valid_r, out_valid_l, overrun_r, overrun_l}, 4'b1100);
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);

      chk("sb_drain_r", exp_q_r.size(), 0);
      chk("sb_drain_l", exp_q_l.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
